// File: rtl/ebike_pkg.sv
// Shared constants and helpers for the e-bike drive datapath.
// Used by cadence_meas and period_avg4.
package ebike_pkg;

    localparam int unsigned CAD_W = 5;
    localparam int unsigned PER_W = 8;

    localparam logic [PER_W-1:0] CAD_SAT        = 8'hFF;
    localparam logic [PER_W-1:0] NOT_PED_THRESH = 8'hF8;

    // Longer average period -> smaller code; top 5 bits inverted.
    function automatic logic [CAD_W-1:0] cad_code(input logic [PER_W-1:0] avg);
        cad_code = 5'd31 - avg[PER_W-1:PER_W-CAD_W];
    endfunction

endpackage

// File: rtl/period_avg4.sv
// Four-deep period sample buffer with a truncating average.
// Ports: clk, rst_n, push (shift din in at [0]), din[7:0], avg[7:0].
module period_avg4
    import ebike_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [PER_W-1:0] din,
    output logic [PER_W-1:0] avg
);

    logic [PER_W-1:0] samples [4];
    logic [PER_W+1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) samples[i] <= CAD_SAT;
        end else if (push) begin
            samples[0] <= din;
            for (int i = 1; i < 4; i++) samples[i] <= samples[i-1];
        end
    end

    always_comb begin
        sum = (10'(samples[0]) + 10'(samples[1]))
            + (10'(samples[2]) + 10'(samples[3]));
    end

    assign avg = sum[PER_W+1:2];

endmodule

// File: rtl/cadence_meas.sv
// Crank cadence measurement: times rise-to-rise intervals in prescaled ticks.
// Ports: clk, rst_n, cadence_filt in; cadence[4:0], not_pedaling out.
module cadence_meas
    import ebike_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cadence_filt,
    output logic [CAD_W-1:0] cadence,
    output logic             not_pedaling
);

    logic                  prev;
    logic                  rise;
    logic [PRESCALE_W-1:0] presc;
    logic                  tick;
    logic [PER_W-1:0]      cnt;
    logic [PER_W-1:0]      avg;
    logic                  stopped;

    assign rise = cadence_filt & ~prev;
    assign tick = &presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= cadence_filt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (rise) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESCALE_W'(1);
        end
    end

    // Edge beats a coincident tick, so exact multiples read one low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (tick && cnt != CAD_SAT) begin
            cnt <= cnt + 8'd1;
        end
    end

    period_avg4 u_avg (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rise),
        .din   (cnt),
        .avg   (avg)
    );

    assign stopped = (cnt == CAD_SAT) | (avg >= NOT_PED_THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cadence      <= '0;
            not_pedaling <= 1'b1;
        end else begin
            not_pedaling <= stopped;
            cadence      <= stopped ? '0 : cad_code(avg);
        end
    end

endmodule

// File: tb/tb_cadence_meas.sv
// Directed bench for cadence_meas with PRESCALE_W=2 (tick every 4 clocks).
// Each scenario task checks its own hand-computed expectations.
module tb_cadence_meas;

    logic       clk;
    logic       rst_n;
    logic       cadence_filt;
    logic [4:0] cadence;
    logic       not_pedaling;

    int n_cmp;
    int n_bad;

    cadence_meas #(.PRESCALE_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_filt (cadence_filt),
        .cadence      (cadence),
        .not_pedaling (not_pedaling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock pulse; rise is sampled at the posedge in the middle.
    // Returns at the negedge just after that posedge.
    task automatic pulse();
        @(negedge clk);
        cadence_filt = 1'b1;
        @(negedge clk);
        cadence_filt = 1'b0;
    endtask

    // n pulses, rises 64 clocks apart.
    task automatic pulses64(input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) repeat (62) @(negedge clk);
            pulse();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cadence_filt = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cadence !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_cadence got %0d want 0", cadence);
        end
        n_cmp++;
        if (not_pedaling !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_notped got %b want 1", not_pedaling);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (cadence !== 5'd0) begin
            n_bad++;
            $display("FAIL idle_cadence got %0d want 0", cadence);
        end
        n_cmp++;
        if (not_pedaling !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_notped got %b want 1", not_pedaling);
        end
    endtask

    task automatic test_steady();
        pulses64(5);
        n_cmp++;
        if (dut.avg !== 8'd15) begin
            n_bad++;
            $display("FAIL steady_avg got %0d want 15", dut.avg);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cadence !== 5'd30) begin
            n_bad++;
            $display("FAIL steady_cadence got %0d want 30", cadence);
        end
        n_cmp++;
        if (not_pedaling !== 1'b0) begin
            n_bad++;
            $display("FAIL steady_notped got %b want 0", not_pedaling);
        end
    endtask

    // Entered at edge k+1 after the last rise (edge k).
    task automatic test_stop();
        repeat (1019) @(posedge clk);
        #1;
        n_cmp++;
        if (dut.cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL stop_cnt got %0d want 255", dut.cnt);
        end
        n_cmp++;
        if (not_pedaling !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_early_notped got %b want 0", not_pedaling);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (not_pedaling !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_notped got %b want 1", not_pedaling);
        end
        n_cmp++;
        if (cadence !== 5'd0) begin
            n_bad++;
            $display("FAIL stop_cadence got %0d want 0", cadence);
        end
    endtask

    task automatic test_resume();
        repeat (20) @(negedge clk);
        pulse();
        n_cmp++;
        if (dut.avg !== 8'd75) begin
            n_bad++;
            $display("FAIL resume_avg got %0d want 75", dut.avg);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cadence !== 5'd22) begin
            n_bad++;
            $display("FAIL resume_cadence got %0d want 22", cadence);
        end
        n_cmp++;
        if (not_pedaling !== 1'b0) begin
            n_bad++;
            $display("FAIL resume_notped got %b want 0", not_pedaling);
        end
    endtask

    task automatic test_held_high();
        @(negedge clk);
        cadence_filt = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++;
        if (dut.cnt !== 8'd49) begin
            n_bad++;
            $display("FAIL held_cnt got %0d want 49", dut.cnt);
        end
        cadence_filt = 1'b0;
    endtask

    task automatic test_coincident();
        pulse();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut.presc !== 2'd2) begin
            n_bad++;
            $display("FAIL coin_presc_pre got %0d want 2", dut.presc);
        end
        pulse();
        n_cmp++;
        if (dut.cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL coin_cnt got %0d want 0", dut.cnt);
        end
        n_cmp++;
        if (dut.presc !== 2'd0) begin
            n_bad++;
            $display("FAIL coin_presc got %0d want 0", dut.presc);
        end
    endtask

    task automatic test_reset_mid();
        repeat (10) @(negedge clk);
        pulses64(5);
        @(posedge clk);
        #1;
        n_cmp++;
        if (cadence !== 5'd30) begin
            n_bad++;
            $display("FAIL mid_pre_cadence got %0d want 30", cadence);
        end
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_outputs got %0d/%b want 0/1",
                     cadence, not_pedaling);
        end
        n_cmp++;
        if (dut.cnt !== 8'd0 || dut.presc !== 2'd0 || dut.prev !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_state got cnt=%0d presc=%0d prev=%b want 0/0/0",
                     dut.cnt, dut.presc, dut.prev);
        end
        n_cmp++;
        if (dut.avg !== 8'd255) begin
            n_bad++;
            $display("FAIL mid_avg got %0d want 255", dut.avg);
        end
        // Input already high at release counts as one rise pushing 0.
        cadence_filt = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dut.avg !== 8'd191) begin
            n_bad++;
            $display("FAIL high_rel_avg got %0d want 191", dut.avg);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cadence !== 5'd8 || not_pedaling !== 1'b0) begin
            n_bad++;
            $display("FAIL high_rel_out got %0d/%b want 8/0",
                     cadence, not_pedaling);
        end
        cadence_filt = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        cadence_filt = 1'b0;
        test_reset();
        test_steady();
        test_stop();
        test_resume();
        test_held_high();
        test_coincident();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
